// File: rtl/crc_n_seq.sv
// crc_n_seq: multi-cycle MSB-first CRC engine, STEP bits per clock, valid/ready on both sides.
// Check mode (mode port, in_crc loading, crc_ok) is enabled by defining CRC_CHECK_EN.
module crc_n_seq #(
  parameter int BW = 4,
  parameter int CRC_BW = 3,
  parameter logic [CRC_BW-1:0] POLY = 3'b011,
  parameter int STEP = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BW-1:0]     in_data,
  input  logic [CRC_BW-1:0] in_crc,
`ifdef CRC_CHECK_EN
  input  logic              mode,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CRC_BW-1:0] CRC,
  output logic              crc_ok,
  output logic              busy
);
  localparam int SW = BW + CRC_BW;
  localparam int NSTEPS = SW / STEP;
  localparam int CW = $clog2(NSTEPS + 1);
  if (BW < 1 || CRC_BW < 2 || STEP < 1 || SW % STEP != 0) begin : g_bad_param
    $error("crc_n_seq: illegal BW/CRC_BW/STEP combination");
  end
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] s_q, s_d, s_nx;
  logic [CRC_BW-1:0] r_q, r_d, r_nx, crc_q, crc_d;
  logic ok_q, ok_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic chk_mode;
`ifdef CRC_CHECK_EN
  assign chk_mode = mode;
  assign crc_ok = ok_q;
`else
  assign chk_mode = 1'b0;
  assign crc_ok = 1'b0;
`endif
  assign in_ready = state_q == IDLE;
  assign busy = state_q == BUSY;
  assign out_valid = state_q == DONE;
  assign CRC = crc_q;
  // STEP unrolled single-bit long-division iterations
  always_comb begin
    s_nx = s_q;
    r_nx = r_q;
    for (int i = 0; i < STEP; i++) begin
      r_nx = {r_nx[CRC_BW-2:0], s_nx[SW-1]} ^ (r_nx[CRC_BW-1] ? POLY : '0);
      s_nx = s_nx << 1;
    end
  end
  always_comb begin
    state_d = state_q;
    s_d = s_q;
    r_d = r_q;
    cnt_d = cnt_q;
    crc_d = crc_q;
    ok_d = ok_q;
    if (state_q == IDLE && in_valid) begin
      s_d = {in_data, chk_mode ? in_crc : {CRC_BW{1'b0}}};
      r_d = '0;
      cnt_d = CW'(NSTEPS);
      state_d = BUSY;
    end else if (state_q == BUSY) begin
      s_d = s_nx;
      r_d = r_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        crc_d = r_nx;
        ok_d = r_nx == '0;
        state_d = DONE;
      end
    end else if (state_q == DONE && out_ready) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      s_q <= '0;
      r_q <= '0;
      cnt_q <= '0;
      crc_q <= '0;
      ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      r_q <= r_d;
      cnt_q <= cnt_d;
      crc_q <= crc_d;
      ok_q <= ok_d;
    end
  end
endmodule

// File: tb/tb_crc_n_seq.sv
// tb_crc_n_seq: drives a STEP=1 and a STEP=7 engine in lockstep and checks them against a long-division model.
module tb_crc_n_seq;
`ifdef CRC_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif
  logic clk, rst_n, in_valid, out_ready, mode;
  logic [3:0] in_data;
  logic [2:0] in_crc;
  logic a_in_ready, a_out_valid, a_crc_ok, a_busy;
  logic b_in_ready, b_out_valid, b_crc_ok, b_busy;
  logic [2:0] a_crc, b_crc;
  int errs = 0, checks = 0;

  crc_n_seq u_s1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_crc(in_crc),
`ifdef CRC_CHECK_EN
    .mode(mode),
`endif
    .out_valid(a_out_valid), .out_ready(out_ready), .CRC(a_crc), .crc_ok(a_crc_ok), .busy(a_busy)
  );
  crc_n_seq #(.STEP(7)) u_s7 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_crc(in_crc),
`ifdef CRC_CHECK_EN
    .mode(mode),
`endif
    .out_valid(b_out_valid), .out_ready(out_ready), .CRC(b_crc), .crc_ok(b_crc_ok), .busy(b_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // remainder of {d,c} modulo x^3 + POLY by textbook polynomial long division
  function automatic logic [2:0] ref_rem(input logic [3:0] d, input logic [2:0] c);
    logic [6:0] m;
    logic [6:0] g;
    m = {d, c};
    g = 7'b0001011;
    for (int i = 6; i >= 3; i--)
      if (m[i]) m = m ^ (g << (i - 3));
    return m[2:0];
  endfunction

  task automatic job(input logic [3:0] d, input logic [2:0] c, input logic md, input int hold);
    logic [2:0] exp_crc;
    logic exp_ok;
    int la, lb;
    exp_crc = ref_rem(d, (CHECK && md) ? c : 3'b000);
    exp_ok = CHECK && exp_crc == 3'b000;
    @(negedge clk);
    in_data = d;
    in_crc = c;
    mode = md;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_data = 4'($urandom);
    in_crc = 3'($urandom);
    mode = 1'($urandom);
    la = -1;
    lb = -1;
    for (int k = 1; k <= 40 && (la < 0 || lb < 0); k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        chk("busy_s1", {a_busy, a_in_ready}, 2'b10);
        chk("done_s7", {b_busy, b_in_ready}, 2'b00);
      end
      if (la < 0 && a_out_valid) la = k;
      if (lb < 0 && b_out_valid) lb = k;
    end
    chk("latency_s1", la, 7);
    chk("latency_s7", lb, 1);
    chk("crc_s1", a_crc, exp_crc);
    chk("crc_s7", b_crc, exp_crc);
    chk("ok_s1", a_crc_ok, exp_ok);
    chk("ok_s7", b_crc_ok, exp_ok);
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk);
      #1;
      chk("hold_s1", {a_out_valid, a_in_ready, a_crc}, {2'b10, exp_crc});
      chk("hold_s7", {b_out_valid, b_in_ready, b_crc}, {2'b10, exp_crc});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("pop_s1", {a_out_valid, a_in_ready, a_busy, a_crc}, {3'b010, exp_crc});
    chk("pop_s7", {b_out_valid, b_in_ready, b_busy, b_crc}, {3'b010, exp_crc});
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    logic seen;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    mode = 1'b0;
    in_data = '0;
    in_crc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("reset_s1", {a_in_ready, a_out_valid, a_busy, a_crc, a_crc_ok}, 7'b1000000);
    chk("reset_s7", {b_in_ready, b_out_valid, b_busy, b_crc, b_crc_ok}, 7'b1000000);
    job(4'b1101, 3'b000, 1'b0, 10);
    job(4'b1000, 3'b000, 1'b0, 0);
    job(4'b0000, 3'b000, 1'b0, 2);
    job(4'b1101, 3'b001, 1'b1, 1);
    job(4'b1101, 3'b011, 1'b1, 0);
    @(negedge clk);
    in_data = 4'b1101;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("midreset_s1", {a_in_ready, a_out_valid, a_busy, a_crc}, 6'b100000);
    chk("midreset_s7", {b_in_ready, b_out_valid, b_busy, b_crc}, 6'b100000);
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      seen = seen | a_out_valid | b_out_valid;
    end
    chk("aborted_no_result", seen, 1'b0);
    for (int n = 0; n < 20; n++)
      job(4'($urandom), 3'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
